// File: rtl/descrypt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : descrypt_pkg
//  Description : Shared types and defaults for the descrypt iteration
//                scheduler (slot record, FSM states, pipeline geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package descrypt_pkg;

    // Default pipeline geometry: 16 DES rounds at 2 cycles each
    localparam int DES_PIPE_LAT = 32;
    // DES passes per descrypt candidate
    localparam int DES_ITERS    = 25;
    localparam int DES_TAG_W    = 8;
    localparam int DES_SALT_W   = 12;
    // Iteration counter width; holds 0..31, enough for ITERS up to 32
    localparam int ITER_W       = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } sched_state_t;

    // One tracker entry, follows its candidate through the round pipeline
    typedef struct packed {
        logic                 valid;
        logic [ITER_W-1:0]    iter;
        logic [DES_TAG_W-1:0] tag;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/descrypt_iter_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : descrypt_iter_sched_if
//  Description : Candidate / datapath-control / salt bus of the descrypt
//                iteration scheduler. The slave side is the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface descrypt_iter_sched_if
    import descrypt_pkg::*;
#(
    parameter int TAG_W  = DES_TAG_W,
    parameter int SALT_W = DES_SALT_W,
    parameter int OCC_W  = $clog2(DES_PIPE_LAT + 1)
);
    logic              in_valid;
    logic [TAG_W-1:0]  in_tag;
    logic              in_ready;
    logic              mux_sel_new;
    logic              mux_load;
    logic              out_valid;
    logic [TAG_W-1:0]  out_tag;
    logic              salt_req;
    logic [SALT_W-1:0] salt_in;
    logic [SALT_W-1:0] salt_out;
    logic              salt_ack;
    logic [OCC_W-1:0]  occupancy;
    logic              busy;

    // Candidate generator / salt controller / datapath side
    modport master (
        output in_valid, in_tag, salt_req, salt_in,
        input  in_ready, mux_sel_new, mux_load, out_valid, out_tag,
               salt_out, salt_ack, occupancy, busy
    );

    // Scheduler side
    modport slave (
        input  in_valid, in_tag, salt_req, salt_in,
        output in_ready, mux_sel_new, mux_load, out_valid, out_tag,
               salt_out, salt_ack, occupancy, busy
    );
endinterface
`default_nettype wire

// File: rtl/descrypt_iter_sched_slot_ring.sv
`default_nettype none
// ============================================================================
//  Module      : sched_slot_ring
//  Description : Per-slot tracker that shadows the round pipeline. Advances
//                every cycle; the write port feeds slot 0 and the last slot
//                is the head (the entry leaving the pipeline this cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module sched_slot_ring
    import descrypt_pkg::*;
#(
    parameter int DEPTH = DES_PIPE_LAT
) (
    input  wire   CLK,
    input  wire   RST,
    input  slot_t i_wr,
    output slot_t o_head
);

    slot_t ring_q [DEPTH];
    slot_t ring_d [DEPTH];

    // Next ring contents: new entry at slot 0, everything else moves up one
    always_comb begin
        ring_d[0] = i_wr;
        for (int i = 1; i < DEPTH; i++) begin
            ring_d[i] = ring_q[i-1];
        end
    end

    // Ring storage; reset invalidates every in-flight entry
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= ring_d[i];
            end
        end
    end

    assign o_head = ring_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/descrypt_iter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : descrypt_iter_sched
//  Description : Schedules descrypt candidates through a free-running 16-round
//                DES pipeline: recirculates each candidate for ITERS passes,
//                fills free slots with new candidates, retires finished
//                hashes and swaps the salt only once the pipeline is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module descrypt_iter_sched
    import descrypt_pkg::*;
#(
    parameter int PIPE_LAT = DES_PIPE_LAT,
    parameter int ITERS    = DES_ITERS,
    parameter int TAG_W    = DES_TAG_W,   // must match the slot_t tag field
    parameter int SALT_W   = DES_SALT_W
) (
    input wire                   CLK,
    input wire                   RST,
    descrypt_iter_sched_if.slave bus
);

    localparam int                OCC_W       = $clog2(PIPE_LAT + 1);
    localparam logic [ITER_W-1:0] c_LAST_ITER = ITER_W'(ITERS - 1);
    localparam logic [ITER_W-1:0] c_ITER_ONE  = ITER_W'(1);
    localparam logic [OCC_W-1:0]  c_OCC_ONE   = OCC_W'(1);

    // Registered state
    sched_state_t      state_q,     state_d;
    logic [SALT_W-1:0] pending_q,   pending_d;
    logic [SALT_W-1:0] salt_out_q,  salt_out_d;
    logic              salt_ack_q,  salt_ack_d;
    logic [OCC_W-1:0]  occupancy_q, occupancy_d;
    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;

    // Per-cycle decision
    slot_t w_head;
    slot_t w_wr;
    logic  w_recirc;
    logic  w_retire;
    logic  w_in_ready;
    logic  w_accept;

    sched_slot_ring #(
        .DEPTH (PIPE_LAT)
    ) u_ring (
        .CLK    (CLK),
        .RST    (RST),
        .i_wr   (w_wr),
        .o_head (w_head)
    );

    // Slot decision: recirculation of an unfinished head always wins; a
    // retiring or empty head frees the slot for a new candidate in RUN.
    always_comb begin
        w_recirc   = w_head.valid && (w_head.iter < c_LAST_ITER);
        w_retire   = w_head.valid && (w_head.iter == c_LAST_ITER);
        w_in_ready = !w_recirc && (state_q == RUN);
        w_accept   = w_in_ready && bus.in_valid;
        w_wr       = '0;
        if (w_recirc) begin
            w_wr.valid = 1'b1;
            w_wr.iter  = w_head.iter + c_ITER_ONE;
            w_wr.tag   = w_head.tag;
        end else if (w_accept) begin
            w_wr.valid = 1'b1;
            w_wr.iter  = '0;
            w_wr.tag   = bus.in_tag;
        end
    end

    // Occupancy bookkeeping and retirement output
    always_comb begin
        occupancy_d = occupancy_q;
        if (w_accept && !w_retire) begin
            occupancy_d = occupancy_q + c_OCC_ONE;
        end else if (w_retire && !w_accept) begin
            occupancy_d = occupancy_q - c_OCC_ONE;
        end
        out_valid_d = w_retire;
        out_tag_d   = w_retire ? w_head.tag : out_tag_q;
    end

    // Salt FSM: latch request, drain the pipeline, then swap in one cycle
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        salt_out_d = salt_out_q;
        salt_ack_d = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.salt_req) begin
                    pending_d = bus.salt_in;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (occupancy_q == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                salt_out_d = pending_q;
                salt_ack_d = 1'b1;
                state_d    = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            pending_q   <= '0;
            salt_out_q  <= '0;
            salt_ack_q  <= 1'b0;
            occupancy_q <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            salt_out_q  <= salt_out_d;
            salt_ack_q  <= salt_ack_d;
            occupancy_q <= occupancy_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.mux_sel_new = !w_recirc && w_accept;
    assign bus.mux_load    = w_recirc || w_accept;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.salt_out    = salt_out_q;
    assign bus.salt_ack    = salt_ack_q;
    assign bus.occupancy   = occupancy_q;
    assign bus.busy        = (state_q != RUN) || (occupancy_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_descrypt_iter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_descrypt_iter_sched
//  Description : Directed bench for descrypt_iter_sched with a tag/cycle
//                scoreboard checked by an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_descrypt_iter_sched;
    import descrypt_pkg::*;

    localparam int LAT = 801;   // accept cycle to out_valid cycle

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    descrypt_iter_sched_if bus ();

    descrypt_iter_sched dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int tag;
        int at;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every retirement must match the oldest expected tag and cycle
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", int'(bus.out_tag), -1);
            end else begin
                e = sb.pop_front();
                chk("out_tag", int'(bus.out_tag), e.tag);
                chk("out_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int tag;
        int loads;
        int sels;
        int bad_space;
        int exp_rdy;

        bus.in_valid = 1'b0;
        bus.in_tag   = '0;
        bus.salt_req = 1'b0;
        bus.salt_in  = '0;

        // ---------------- reset state ----------------
        RST = 1'b1;
        step();
        step();
        @(negedge CLK);
        chk("rst_occupancy", int'(bus.occupancy), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_tag",   int'(bus.out_tag),   0);
        chk("rst_salt_out",  int'(bus.salt_out),  0);
        chk("rst_salt_ack",  int'(bus.salt_ack),  0);
        chk("rst_busy",      int'(bus.busy),      0);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        step();
        RST = 1'b0;
        repeat (3) step();

        // ---------------- single candidate ----------------
        t0 = cyc;
        bus.in_valid = 1'b1;
        bus.in_tag   = 8'h5A;
        @(negedge CLK);
        chk("single_in_ready", int'(bus.in_ready), 1);
        chk("single_sel_new",  int'(bus.mux_sel_new), 1);
        chk("single_load",     int'(bus.mux_load), 1);
        sb.push_back('{32'h5A, t0 + LAT});
        step();
        bus.in_valid = 1'b0;
        loads = 1;
        sels = 1;
        bad_space = 0;
        for (int k = 1; k <= 850; k++) begin
            @(negedge CLK);
            if (k == 1) chk("single_occ_1", int'(bus.occupancy), 1);
            if (bus.mux_load === 1'b1) begin
                loads++;
                if (((cyc - t0) % 32) != 0) bad_space++;
            end
            if (bus.mux_sel_new === 1'b1) sels++;
            step();
        end
        chk("single_load_count",   loads, 25);
        chk("single_sel_count",    sels, 1);
        chk("single_load_spacing", bad_space, 0);
        chk("single_sb_empty",     sb.size(), 0);
        @(negedge CLK);
        chk("single_occ_end", int'(bus.occupancy), 0);
        step();

        // ---------------- fill ----------------
        t0 = cyc;
        tag = 0;
        for (int j = 0; j < 900; j++) begin
            bus.in_valid = (tag <= 40);
            bus.in_tag   = 8'(tag);
            @(negedge CLK);
            exp_rdy = ((j < 32) || (j >= 800 && j < 840 && j < 832)) ? 1 : 0;
            if (j < 840) chk("fill_in_ready", int'(bus.in_ready), exp_rdy);
            if (j == 31)  chk("fill_occ_31",  int'(bus.occupancy), 31);
            if (j == 32)  chk("fill_occ_32",  int'(bus.occupancy), 32);
            if (j == 800) chk("fill_occ_800", int'(bus.occupancy), 32);
            if (j == 801) chk("fill_occ_801", int'(bus.occupancy), 32);
            if (j == 800) chk("fill_sel_new_800", int'(bus.mux_sel_new), 1);
            if (bus.in_valid && exp_rdy == 1) begin
                sb.push_back('{tag, cyc + LAT});
                tag++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("fill_sb_empty", sb.size(), 0);
        repeat (3) step();
        @(negedge CLK);
        chk("fill_occ_end", int'(bus.occupancy), 0);
        step();

        // ---------------- salt change while full ----------------
        for (int j = 0; j < 845; j++) begin
            bus.in_valid = (j < 32);
            bus.in_tag   = 8'(8'h80 + j);
            bus.salt_req = (j == 100);
            bus.salt_in  = 12'hABC;
            @(negedge CLK);
            if (j < 32) begin
                chk("full_in_ready", int'(bus.in_ready), 1);
                sb.push_back('{8'h80 + j, cyc + LAT});
            end
            if (j >= 101) begin
                chk("drain_in_ready", int'(bus.in_ready), (j >= 834) ? 1 : 0);
                chk("drain_salt_out", int'(bus.salt_out), (j >= 834) ? 32'hABC : 0);
                chk("drain_salt_ack", int'(bus.salt_ack), (j == 834) ? 1 : 0);
            end
            if (j == 833) chk("drain_busy_load", int'(bus.busy), 1);
            if (j == 835) chk("drain_busy_idle", int'(bus.busy), 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.salt_req = 1'b0;
        chk("full_sb_empty", sb.size(), 0);

        // ---------------- salt change while empty ----------------
        for (int j = 0; j < 6; j++) begin
            bus.salt_req = (j < 2);
            bus.salt_in  = (j == 0) ? 12'h123 : 12'h777;
            @(negedge CLK);
            case (j)
                0: chk("empty_in_ready_0", int'(bus.in_ready), 1);
                1: begin
                    chk("empty_in_ready_1", int'(bus.in_ready), 0);
                    chk("empty_busy_1",     int'(bus.busy), 1);
                    chk("empty_salt_old",   int'(bus.salt_out), 32'hABC);
                end
                2: begin
                    chk("empty_in_ready_2", int'(bus.in_ready), 0);
                    chk("empty_ack_2",      int'(bus.salt_ack), 0);
                end
                3: begin
                    chk("empty_salt_new",   int'(bus.salt_out), 32'h123);
                    chk("empty_ack_3",      int'(bus.salt_ack), 1);
                    chk("empty_in_ready_3", int'(bus.in_ready), 1);
                end
                4: begin
                    chk("empty_ack_4",      int'(bus.salt_ack), 0);
                    chk("empty_salt_hold",  int'(bus.salt_out), 32'h123);
                    chk("empty_busy_4",     int'(bus.busy), 0);
                end
                default: ;
            endcase
            step();
        end
        bus.salt_req = 1'b0;

        // ---------------- reset mid-run ----------------
        loads = 0;
        for (int j = 0; j < 960; j++) begin
            bus.in_valid = (j < 10);
            bus.in_tag   = 8'(8'hC0 + j);
            RST = (j == 50);
            @(negedge CLK);
            if (j < 10)  chk("rr_in_ready", int'(bus.in_ready), 1);
            if (j == 49) chk("rr_occ_before", int'(bus.occupancy), 10);
            if (j == 51) begin
                chk("rr_occupancy", int'(bus.occupancy), 0);
                chk("rr_salt_out",  int'(bus.salt_out), 0);
                chk("rr_in_ready_after", int'(bus.in_ready), 1);
                chk("rr_out_valid", int'(bus.out_valid), 0);
                chk("rr_busy",      int'(bus.busy), 0);
            end
            if (j > 51 && bus.mux_load === 1'b1) loads++;
            step();
        end
        RST = 1'b0;
        chk("rr_no_recirc", loads, 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/descrypt_iter_sched.md
Name: descrypt_iter_sched

Overview:
- Sequences a 16-round DES crypt_step pipeline (2 cycles/round, no clock enable) through the 25 descrypt iterations.
- Tracks a tag and iteration count for every pipeline slot. Decides each cycle whether the datapath input mux takes a new candidate or recirculates the pipeline head.
- Retires finished hashes and gates salt reconfiguration behind a full pipeline drain.
- Sits between the candidate generator and the round pipeline plus hash comparator.

Parameters:
- PIPE_LAT, 32, total pipeline latency in cycles (16 rounds x 2).
- ITERS, 25, DES passes per candidate.
- TAG_W, 8, candidate tag width.
- SALT_W, 12, salt width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  candidate available.
- in_tag  in  TAG_W  candidate tag.
- in_ready  out  1  candidate accepted this cycle when in_valid&&in_ready; combinational.
- mux_sel_new  out  1  1 = datapath loads new candidate (zero block), 0 = recirculate head; combinational.
- mux_load  out  1  slot entering pipeline is valid; combinational.
- out_valid  out  1  one-cycle pulse, hash at head is final; registered.
- out_tag  out  TAG_W  tag of the retired candidate; registered.
- salt_req  in  1  pulse, request salt change.
- salt_in  in  SALT_W  new salt, sampled with salt_req.
- salt_out  out  SALT_W  active salt to the Fblock E-expansion; registered.
- salt_ack  out  1  one-cycle pulse, salt_out updated.
- occupancy  out  clog2(PIPE_LAT+1)  valid slots in flight.
- busy  out  1  state != RUN or occupancy != 0.

Behaviour:
- Reset values (RST sampled at the CLK edge): all tracker slots invalid; occupancy=0; out_valid=0; out_tag=0; salt_out=0; salt_ack=0; state=RUN. Reset mid-operation discards all in-flight candidates with no out_valid.
- Tracker: shift register s[0..PIPE_LAT-1] of {valid, iter[4:0], tag}, advancing every cycle unconditionally. Head = s[PIPE_LAT-1]. An entry written at the end of cycle t is at the head in cycle t+PIPE_LAT.
- Each-cycle decision, in priority order:
  - Recirc: head.valid && head.iter<ITERS-1. Write {1, iter+1, tag}; mux_sel_new=0; mux_load=1; in_ready=0.
  - Retire: head.valid && head.iter==ITERS-1. Next cycle out_valid=1 and out_tag=head.tag. The slot is then free.
  - Free slot (head invalid or retiring):
    - in_ready = (state==RUN).
    - On accept: write {1,0,in_tag}; mux_sel_new=1; mux_load=1.
    - Otherwise: write invalid; mux_load=0; mux_sel_new=0.
- Recirculation always beats new input; the pipeline never stalls, and out_valid has no backpressure.
- Latency: accept in cycle t gives out_valid in cycle t+ITERS*PIPE_LAT+1 (801 at defaults). Tags retire in acceptance order.
- Occupancy:
  - +1 on accept, -1 on retire, unchanged when both occur in the same cycle.
  - Never exceeds PIPE_LAT, never underflows.
- FSM:
  - RUN: salt_req registers pending=salt_in, then goes to DRAIN.
  - DRAIN: in_ready=0; recirculation and retirement continue. When occupancy==0, go to LOAD.
  - LOAD (1 cycle): salt_out<=pending; salt_ack=1 in the following cycle; go to RUN.
- salt_req is ignored in DRAIN and LOAD. salt_req with an empty pipeline spends 1 cycle in DRAIN.
- salt_req together with an accepted candidate: the candidate is accepted and runs under the old salt.

Decomposition:
- descrypt_pkg holds:
  - ITERS and PIPE_LAT defaults, SALT_W.
  - sched_state_t enum {RUN, DRAIN, LOAD}.
  - slot_t packed struct {valid, iter, tag}.
- Sub-module sched_slot_ring: the tracker shift register with head output and write port. Decision logic, occupancy and FSM stay in descrypt_iter_sched.

Test Plan:
- Single candidate: in_tag=0x5A accepted at cycle 10 -> out_valid with out_tag=0x5A at cycle 811 only. mux_sel_new=1 once; mux_load=1 for 25 cycles spaced 32 apart.
- Fill: in_valid held high with tags 0..40 -> tags 0..31 accepted in cycles 0..31; in_ready=0 until the first retire. Outputs 0..31 appear in order on consecutive cycles 801..832. Tag 32 is accepted in cycle 800, the retire/free cycle, and occupancy stays 32 there.
- Salt change while full: salt_req with salt_in=0xABC at cycle 100 -> in_ready=0 from cycle 101. salt_out stays 0 until all 32 retire; salt_out=0xABC with salt_ack one cycle after LOAD, then in_ready returns.
- Salt change while empty: salt_req with 0x123 -> DRAIN 1 cycle, LOAD, salt_out=0x123 and salt_ack 3 cycles after the request. A second salt_req during DRAIN is ignored.
- Reset mid-run: 10 candidates in flight, RST for 1 cycle -> occupancy=0, no out_valid ever for those tags, salt_out=0, in_ready=1 the next cycle.
